// File: rtl/sram_pkg.sv
// Shared constants and helpers for the SRAM family: RDW mode names, byte merge,
// even parity and a parameter sanity check.
package sram_pkg;

  localparam string RDW_READ_FIRST  = "READ_FIRST";
  localparam string RDW_WRITE_FIRST = "WRITE_FIRST";
  localparam string PIPE_ON         = "TRUE";

  // Helpers operate on the widest supported word; callers cast in and out.
  localparam int unsigned MAX_WIDTH = 256;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_WIDTH);

  function automatic bit addr_size_ok(input int unsigned depth, input int unsigned addr_size);
    return (depth > 0) && ($clog2(depth) <= addr_size);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] byte_merge(
    input logic [MAX_WIDTH-1:0] old_w,
    input logic [MAX_WIDTH-1:0] new_w,
    input logic [MAX_WIDTH-1:0] be,
    input int unsigned          byte_width
  );
    logic [MAX_WIDTH-1:0] r;
    r = old_w;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (be[MAX_IDX_W'(i / byte_width)]) r[MAX_IDX_W'(i)] = new_w[MAX_IDX_W'(i)];
    end
    return r;
  endfunction

  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/sram_port_pipe.sv
// Per-port read output stage: optional second register, valid alignment and
// (with TDPSRAM_PARITY_EN) a parity register that tracks dout.
module sram_port_pipe
  import sram_pkg::*;
#(
  parameter int unsigned MEM_WIDTH     = 16,
  parameter string       DOUT_PIPELINE = "TRUE"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [MEM_WIDTH-1:0] in_data,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 dout_valid
`ifdef TDPSRAM_PARITY_EN
  ,
  output logic                 parity
`endif
);

  logic                 s1_valid;
  logic [MEM_WIDTH-1:0] s1_data;

  // First stage is loaded on the accept edge; data holds while no read arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= in_data;
    end
  end

  if (DOUT_PIPELINE == PIPE_ON) begin : g_reg
    logic                 s2_valid;
    logic [MEM_WIDTH-1:0] s2_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign dout       = s2_data;
    assign dout_valid = s2_valid;

`ifdef TDPSRAM_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           par_q <= 1'b0;
      else if (s1_valid) par_q <= even_parity(MAX_WIDTH'(s1_data));
    end
    assign parity = par_q;
`endif
  end else begin : g_bypass
    assign dout       = s1_data;
    assign dout_valid = s1_valid;

`ifdef TDPSRAM_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           par_q <= 1'b0;
      else if (in_valid) par_q <= even_parity(MAX_WIDTH'(in_data));
    end
    assign parity = par_q;
`endif
  end

endmodule

// File: rtl/tdpsram.sv
// True dual-port synchronous SRAM with byte enables, RDW mode, optional output
// register and collision flag. Optional parity outputs: TDPSRAM_PARITY_EN.
module tdpsram
  import sram_pkg::*;
#(
  parameter int unsigned MEM_WIDTH     = 16,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned MEM_DEPTH     = 1024,
  parameter int unsigned ADDR_SIZE     = 10,
  parameter string       DOUT_PIPELINE = "TRUE",
  parameter string       RDW_MODE      = "READ_FIRST"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MEM_WIDTH-1:0]            din_a,
  input  logic [MEM_WIDTH-1:0]            din_b,
  input  logic [ADDR_SIZE-1:0]            addr_a,
  input  logic [ADDR_SIZE-1:0]            addr_b,
  input  logic [MEM_WIDTH/BYTE_WIDTH-1:0] be_a,
  input  logic [MEM_WIDTH/BYTE_WIDTH-1:0] be_b,
  input  logic                            wr_en_a,
  input  logic                            wr_en_b,
  input  logic                            rd_en_a,
  input  logic                            rd_en_b,
  input  logic                            blk_select_a,
  input  logic                            blk_select_b,
  output logic [MEM_WIDTH-1:0]            dout_a,
  output logic [MEM_WIDTH-1:0]            dout_b,
  output logic                            dout_valid_a,
  output logic                            dout_valid_b,
  output logic                            collision
`ifdef TDPSRAM_PARITY_EN
  ,
  output logic                            parity_a,
  output logic                            parity_b
`endif
);

  localparam int unsigned          LANES       = MEM_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_SIZE:0]   DEPTH_L     = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam bit                   WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  if (!addr_size_ok(MEM_DEPTH, ADDR_SIZE) || (MEM_WIDTH % BYTE_WIDTH) != 0 ||
      MEM_WIDTH > MAX_WIDTH) begin : g_param_err
    $error("tdpsram: inconsistent MEM_WIDTH/BYTE_WIDTH/MEM_DEPTH/ADDR_SIZE");
  end

  function automatic logic [MEM_WIDTH-1:0] merge_w(
    input logic [MEM_WIDTH-1:0] old_w,
    input logic [MEM_WIDTH-1:0] new_w,
    input logic [LANES-1:0]     be
  );
    return MEM_WIDTH'(byte_merge(MAX_WIDTH'(old_w), MAX_WIDTH'(new_w), MAX_WIDTH'(be), BYTE_WIDTH));
  endfunction

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  logic                 wr_a, wr_b, rd_a, rd_b;
  logic                 rng_a, rng_b, addr_eq, conflict;
  logic [MEM_WIDTH-1:0] old_a, old_b, rd_word_a, rd_word_b;

  // Requests seen while rst is high are dropped here, before the array.
  assign wr_a    = !rst && blk_select_a && wr_en_a;
  assign wr_b    = !rst && blk_select_b && wr_en_b;
  assign rd_a    = !rst && blk_select_a && rd_en_a;
  assign rd_b    = !rst && blk_select_b && rd_en_b;
  assign rng_a   = {1'b0, addr_a} < DEPTH_L;
  assign rng_b   = {1'b0, addr_b} < DEPTH_L;
  assign addr_eq = (addr_a == addr_b);
  assign old_a   = mem[addr_a];
  assign old_b   = mem[addr_b];

  assign conflict = addr_eq && ((wr_a && (wr_b || rd_b)) || (wr_b && rd_a));

  // Same-address dual write: B lanes land first, then A overrides its lanes.
  always_ff @(posedge clk) begin
    if (wr_a && rng_a && wr_b && rng_b && addr_eq) begin
      mem[addr_a] <= merge_w(merge_w(old_a, din_b, be_b), din_a, be_a);
    end else begin
      if (wr_a && rng_a) mem[addr_a] <= merge_w(old_a, din_a, be_a);
      if (wr_b && rng_b) mem[addr_b] <= merge_w(old_b, din_b, be_b);
    end
  end

  // Only a port's own write is visible in WRITE_FIRST; the other port's never is.
  always_comb begin
    rd_word_a = '0;
    rd_word_b = '0;
    if (rng_a) rd_word_a = (WRITE_FIRST && wr_a) ? merge_w(old_a, din_a, be_a) : old_a;
    if (rng_b) rd_word_b = (WRITE_FIRST && wr_b) ? merge_w(old_b, din_b, be_b) : old_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) collision <= 1'b0;
    else     collision <= conflict;
  end

  sram_port_pipe #(.MEM_WIDTH(MEM_WIDTH), .DOUT_PIPELINE(DOUT_PIPELINE)) u_pipe_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (rd_a),
    .in_data    (rd_word_a),
    .dout       (dout_a),
    .dout_valid (dout_valid_a)
`ifdef TDPSRAM_PARITY_EN
    ,
    .parity     (parity_a)
`endif
  );

  sram_port_pipe #(.MEM_WIDTH(MEM_WIDTH), .DOUT_PIPELINE(DOUT_PIPELINE)) u_pipe_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (rd_b),
    .in_data    (rd_word_b),
    .dout       (dout_b),
    .dout_valid (dout_valid_b)
`ifdef TDPSRAM_PARITY_EN
    ,
    .parity     (parity_b)
`endif
  );

endmodule

// File: tb/tb_tdpsram.sv
// Bench for tdpsram: two instances (pipelined READ_FIRST, unpipelined WRITE_FIRST)
// share one random stimulus stream and are checked against a word-level model.
module tb_tdpsram;

  localparam int unsigned W     = 16;
  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned NCYC  = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             sel [2], we [2], re [2];
  logic [AW-1:0]    addr [2];
  logic [W-1:0]     din [2];
  logic [LANES-1:0] be [2];

  logic [W-1:0] dout_f [2], dout_p [2];
  logic         vld_f [2], vld_p [2];
  logic         coll_f, coll_p;
`ifdef TDPSRAM_PARITY_EN
  logic         par_f [2], par_p [2];
`endif

  tdpsram #(.DOUT_PIPELINE("TRUE"), .RDW_MODE("READ_FIRST")) dut_p (
    .clk(clk), .rst(rst),
    .din_a(din[0]), .din_b(din[1]), .addr_a(addr[0]), .addr_b(addr[1]),
    .be_a(be[0]), .be_b(be[1]), .wr_en_a(we[0]), .wr_en_b(we[1]),
    .rd_en_a(re[0]), .rd_en_b(re[1]), .blk_select_a(sel[0]), .blk_select_b(sel[1]),
    .dout_a(dout_p[0]), .dout_b(dout_p[1]), .dout_valid_a(vld_p[0]), .dout_valid_b(vld_p[1]),
    .collision(coll_p)
`ifdef TDPSRAM_PARITY_EN
    , .parity_a(par_p[0]), .parity_b(par_p[1])
`endif
  );

  tdpsram #(.DOUT_PIPELINE("FALSE"), .RDW_MODE("WRITE_FIRST")) dut_f (
    .clk(clk), .rst(rst),
    .din_a(din[0]), .din_b(din[1]), .addr_a(addr[0]), .addr_b(addr[1]),
    .be_a(be[0]), .be_b(be[1]), .wr_en_a(we[0]), .wr_en_b(we[1]),
    .rd_en_a(re[0]), .rd_en_b(re[1]), .blk_select_a(sel[0]), .blk_select_b(sel[1]),
    .dout_a(dout_f[0]), .dout_b(dout_f[1]), .dout_valid_a(vld_f[0]), .dout_valid_b(vld_f[1]),
    .collision(coll_f)
`ifdef TDPSRAM_PARITY_EN
    , .parity_a(par_f[0]), .parity_b(par_f[1])
`endif
  );

  // Reference model: word array plus a per-edge log of accepted reads.
  logic [W-1:0] mem_m [DEPTH];
  logic         av  [2][NCYC];
  logic [W-1:0] arf [2][NCYC];
  logic [W-1:0] awf [2][NCYC];
  logic [W-1:0] hold_f [2], hold_p [2];
  logic         exp_vf [2], exp_vp [2];
  logic         coll_exp;
  int           n;
  int           n_pass, n_total;

  function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] nw,
                                         input logic [LANES-1:0] b);
    logic [W-1:0] r;
    r = o;
    for (int l = 0; l < LANES; l++) if (b[l]) r[l*8 +: 8] = nw[l*8 +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_outputs();
    for (int p = 0; p < 2; p++) begin
      check($sformatf("f_dout_%0d@%0d", p, n), 32'(dout_f[p]), 32'(hold_f[p]));
      check($sformatf("f_vld_%0d@%0d", p, n),  32'(vld_f[p]),  32'(exp_vf[p]));
      check($sformatf("p_dout_%0d@%0d", p, n), 32'(dout_p[p]), 32'(hold_p[p]));
      check($sformatf("p_vld_%0d@%0d", p, n),  32'(vld_p[p]),  32'(exp_vp[p]));
`ifdef TDPSRAM_PARITY_EN
      check($sformatf("f_par_%0d@%0d", p, n), 32'(par_f[p]), 32'(^hold_f[p]));
      check($sformatf("p_par_%0d@%0d", p, n), 32'(par_p[p]), 32'(^hold_p[p]));
`endif
    end
    check($sformatf("f_coll@%0d", n), 32'(coll_f), 32'(coll_exp));
    check($sformatf("p_coll@%0d", n), 32'(coll_p), 32'(coll_exp));
  endtask

  // One clock: evaluate the rules on the current inputs, clock, then compare.
  task automatic step();
    logic         ra [2], wa [2];
    logic [W-1:0] rf [2], wf [2];
    logic         cf;
    for (int p = 0; p < 2; p++) begin
      wa[p] = !rst && sel[p] && we[p];
      ra[p] = !rst && sel[p] && re[p];
      rf[p] = (addr[p] < DEPTH) ? mem_m[addr[p]] : '0;
      wf[p] = (wa[p] && addr[p] < DEPTH) ? merge(mem_m[addr[p]], din[p], be[p]) : rf[p];
    end
    cf = (addr[0] == addr[1]) && ((wa[0] && (wa[1] || ra[1])) || (wa[1] && ra[0]));
    @(posedge clk);
    n++;
    for (int p = 0; p < 2; p++) begin
      av[p][n]  = ra[p];
      arf[p][n] = rf[p];
      awf[p][n] = wf[p];
    end
    for (int p = 1; p >= 0; p--)
      if (wa[p] && addr[p] < DEPTH) mem_m[addr[p]] = merge(mem_m[addr[p]], din[p], be[p]);
    coll_exp = cf;
    #1;
    for (int p = 0; p < 2; p++) begin
      exp_vf[p] = av[p][n];
      exp_vp[p] = av[p][n-1];
      if (exp_vf[p]) hold_f[p] = awf[p][n];
      if (exp_vp[p]) hold_p[p] = arf[p][n-1];
    end
    check_outputs();
  endtask

  task automatic drive(input int p, input logic s, input logic w, input logic r,
                       input logic [AW-1:0] a, input logic [W-1:0] d, input logic [LANES-1:0] b);
    sel[p] = s; we[p] = w; re[p] = r; addr[p] = a; din[p] = d; be[p] = b;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) drive(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Async reset asserted between edges; anything in flight is discarded.
  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    for (int p = 0; p < 2; p++) begin
      av[p][n] = 1'b0;
      hold_f[p] = '0; hold_p[p] = '0;
      exp_vf[p] = 1'b0; exp_vp[p] = 1'b0;
    end
    coll_exp = 1'b0;
    check_outputs();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(1) == 0) return AW'($urandom_range(3));
    return AW'($urandom_range(DEPTH - 1));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle();
    n = 0; n_pass = 0; n_total = 0; coll_exp = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < NCYC; c++) begin av[p][c] = 1'b0; arf[p][c] = '0; awf[p][c] = '0; end
      hold_f[p] = '0; hold_p[p] = '0; exp_vf[p] = 1'b0; exp_vp[p] = 1'b0;
    end
    #1 rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Fill every word with known random contents.
    for (int i = 0; i < DEPTH / 2; i++) begin
      drive(0, 1'b1, 1'b1, 1'b0, AW'(2 * i),     W'($urandom), 2'b11);
      drive(1, 1'b1, 1'b1, 1'b0, AW'(2 * i + 1), W'($urandom), 2'b11);
      step();
    end
    idle();

    // Write on A, read back on B.
    drive(0, 1'b1, 1'b1, 1'b0, 10'd5, 16'hBEEF, 2'b11); step(); idle();
    drive(1, 1'b1, 1'b0, 1'b1, 10'd5, 16'h0000, 2'b00); step(); idle();
    check("beef_f", 32'(dout_f[1]), 32'h0000_BEEF);
    step();
    check("beef_p",     32'(dout_p[1]), 32'h0000_BEEF);
    check("beef_p_vld", 32'(vld_p[1]),  32'd1);

    // Upper-byte-only write.
    drive(0, 1'b1, 1'b1, 1'b0, 10'd7, 16'h1234, 2'b11); step();
    drive(0, 1'b1, 1'b1, 1'b0, 10'd7, 16'hABCD, 2'b10); step();
    drive(0, 1'b1, 1'b0, 1'b1, 10'd7, 16'h0000, 2'b00); step(); idle();
    check("be_f", 32'(dout_f[0]), 32'h0000_AB34);
    step();
    check("be_p", 32'(dout_p[0]), 32'h0000_AB34);

    // Same-port read during write.
    drive(0, 1'b1, 1'b1, 1'b0, 10'd3, 16'h0001, 2'b11); step();
    drive(0, 1'b1, 1'b1, 1'b1, 10'd3, 16'h00FF, 2'b11); step(); idle();
    check("rdw_write_first", 32'(dout_f[0]), 32'h0000_00FF);
    step();
    check("rdw_read_first",  32'(dout_p[0]), 32'h0000_0001);

    // Dual write to one address.
    drive(0, 1'b1, 1'b1, 1'b0, 10'd9, 16'h1111, 2'b01);
    drive(1, 1'b1, 1'b1, 1'b0, 10'd9, 16'h2222, 2'b11); step(); idle();
    check("coll_pulse", 32'(coll_p), 32'd1);
    step();
    check("coll_clear", 32'(coll_p), 32'd0);
    drive(0, 1'b1, 1'b0, 1'b1, 10'd9, 16'h0000, 2'b00); step(); idle();
    check("dual_wr_f", 32'(dout_f[0]), 32'h0000_2211);
    step();
    check("dual_wr_p", 32'(dout_p[0]), 32'h0000_2211);

`ifdef TDPSRAM_PARITY_EN
    drive(0, 1'b1, 1'b1, 1'b0, 10'd20, 16'h0007, 2'b11);
    drive(1, 1'b1, 1'b1, 1'b0, 10'd21, 16'h0003, 2'b11); step(); idle();
    drive(0, 1'b1, 1'b0, 1'b1, 10'd20, 16'h0000, 2'b00); step();
    check("par_f_7", 32'(par_f[0]), 32'd1);
    drive(0, 1'b1, 1'b0, 1'b1, 10'd21, 16'h0000, 2'b00); step(); idle();
    check("par_f_3", 32'(par_f[0]), 32'd0);
    check("par_p_7", 32'(par_p[0]), 32'd1);
    step();
    check("par_p_3", 32'(par_p[0]), 32'd0);
`endif

    // Reset with a read in flight, requests during reset ignored.
    drive(0, 1'b1, 1'b0, 1'b1, 10'd5, 16'h0000, 2'b00); step(); idle();
    reset_mid();
    check("rst_dout_p", 32'(dout_p[0]), 32'd0);
    check("rst_vld_f",  32'(vld_f[0]),  32'd0);
    drive(0, 1'b1, 1'b1, 1'b1, 10'd5, 16'h5555, 2'b11); step(); idle();
    rst = 1'b0;
    step();
    check("rst_drop_p", 32'(vld_p[0]), 32'd0);
    drive(1, 1'b1, 1'b0, 1'b1, 10'd5, 16'h0000, 2'b00); step(); idle();
    check("rst_keep_mem", 32'(dout_f[1]), 32'h0000_BEEF);
    step();

    // Back-to-back reads every cycle with random writes mixed in.
    for (int c = 0; c < 200; c++) begin
      for (int p = 0; p < 2; p++)
        drive(p, 1'b1, ($urandom_range(9) < 3), 1'b1, rand_addr(), W'($urandom),
              LANES'($urandom_range(3)));
      if (c == 100) begin addr[0] = 10'd1023; addr[1] = 10'd0;    end
      if (c == 101) begin addr[0] = 10'd0;    addr[1] = 10'd1023; end
      step();
    end

    // Fully random request mix.
    for (int c = 0; c < 60; c++) begin
      for (int p = 0; p < 2; p++)
        drive(p, ($urandom_range(3) != 0), $urandom_range(1) == 1, $urandom_range(1) == 1,
              rand_addr(), W'($urandom), LANES'($urandom_range(3)));
      step();
    end
    idle();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
